axi_sram_rd_slave: RTL
======================

Name: axi_sram_rd_slave

Overview:
AXI4 read-channel responder backed by an on-chip word array. It is the memory-side end of the instruction-fetch read path: it serves ICache line fills (INCR/WRAP bursts) and single-beat uncached fetches issued by the IFU. It is used in simulation and non-SoC builds in place of the SoC memory, so it must honour full AR/R handshake semantics, including R backpressure.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of word 0.
- DEPTH_LOG2, 16, log2 of the number of 32-bit words.
- LATENCY, 2, number of idle cycles between AR acceptance and the first R beat (0 allowed).
- ID_W, 4, width of arid/rid.

Ports:
- clock  in  1  clock
- reset  in  1  reset
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- araddr  in  32  burst start byte address
- arid  in  ID_W  transaction id
- arlen  in  8  beats minus 1
- arsize  in  3  log2 bytes per beat
- arburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP
- rvalid  out  1  R valid
- rready  in  1  R ready
- rdata  out  32  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast  out  1  final beat
- rid  out  ID_W  echoed arid
- init_we  in  1  preload write enable
- init_addr  in  32  preload byte address
- init_wdata  in  32  preload data
- init_wstrb  in  4  preload byte strobes

Behaviour:
- Reset: reset is synchronous and active-high; clock is clock. On reset the FSM enters IDLE. Reset values: arready=0 in the reset cycle and 1 afterwards; rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. Array contents are not reset.
- FSM states: IDLE, WAIT, BURST.
  - IDLE: arready=1. When arvalid=1, latch addr, id, len, size, burst and errors. Go to WAIT if LATENCY>0, otherwise to BURST. The first rvalid appears LATENCY+1 cycles after the AR handshake edge.
  - WAIT: arready=0. A counter runs down from LATENCY-1; at 0, go to BURST.
  - BURST: arready=0, rvalid=1.
- R channel rules while rvalid=1 and rready=0: rdata, rresp, rlast and rid are held stable.
- Beat handshake (rvalid & rready): advance the address and increment the beat counter. On the beat where counter==len, rlast=1. Its handshake returns the FSM to IDLE with rvalid=0 in the next cycle. There are no back-to-back bursts without an IDLE cycle.
- Address update per handshake, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr += step, 32-bit wrap-around.
  - WRAP: boundary = (len+1)*step. addr = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
- Data: rdata = mem[(addr-BASE_ADDR)>>2], full word regardless of size. The address is not realigned; the low 2 bits are ignored for indexing.
- Errors, with rresp constant for the whole burst:
  - size>2 → SLVERR.
  - WRAP with len not in {1,3,7,15} → SLVERR.
  - Otherwise, a beat whose address is outside [BASE_ADDR, BASE_ADDR+4*2^DEPTH_LOG2) → DECERR for that beat, with rdata=0.
  - Error bursts still deliver exactly len+1 beats with correct rlast.
  - SLVERR beats have rdata=0.
- Preload: init_we is accepted only in IDLE. It writes the bytes selected by init_wstrb, taking effect at the clock edge. init_we outside IDLE is ignored (non-SYNTHESIS builds print an error). If init_we and an AR handshake occur in the same IDLE cycle, the write lands before any beat reads.
- Reset mid-burst: the burst is abandoned, rvalid drops in the cycle after reset, and no further beats are issued for it.

Optional Feature:
- Macro: AXI_SRAM_RAND_DELAY_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset, polynomial x^16+x^14+x^13+x^11+1) steps every cycle.
  - In BURST, a bubble is inserted before presenting a beat when lfsr[1:0]==0. During the bubble, rvalid=0 for one cycle; this never happens while a beat is pending and unaccepted.
  - WAIT length becomes LATENCY+lfsr[3:0] for each burst.
- Undefined: fixed timing exactly as above; the LFSR is absent.

Test Plan:
- Preload mem[0..3]=11,22,33,44. AR araddr=0x80000000, len=3, size=2, INCR, LATENCY=2, rready=1 → rvalid rises 3 cycles after the AR edge. Four consecutive beats 11,22,33,44 with rresp=00 and rlast only on 44.
- Same preload, WRAP len=3 araddr=0x80000008 → beats 33,44,11,22, rlast on 22.
- Same burst as the first, with rready toggled 1,0,0,1,0,1… → each beat is held stable while stalled. All beats 11,22,33,44 are delivered in order, with no beat lost or duplicated.
- araddr=0x7FFFFFFC, len=1, INCR → beat0 DECERR with rdata=0, beat1 (0x80000000) OKAY with data 11. arsize=3 → both beats SLVERR.
- Assert reset during beat 2 of a len=7 burst → rvalid=0 after reset. arready=1 in the following cycle; a new AR with arid=5 returns rid=5 with correct data.
- init_we in BURST to 0x80000000 with wstrb=4'b0011, data 0xFFFF → write ignored; a later read returns 11. The same write in IDLE → a later read returns 0x0000FFFF.

Source files
------------

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read-only responder over an on-chip word array with a side preload port.
// Define AXI_SRAM_RAND_DELAY_EN to add LFSR-driven random WAIT lengths and R-beat bubbles.
module axi_sram_rd_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int          DEPTH_LOG2 = 16,
    parameter int          LATENCY    = 2,
    parameter int          ID_W       = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            arvalid,
    output logic            arready,
    input  logic [31:0]     araddr,
    input  logic [ID_W-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    output logic            rvalid,
    input  logic            rready,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic [ID_W-1:0] rid,
    input  logic            init_we,
    input  logic [31:0]     init_addr,
    input  logic [31:0]     init_wdata,
    input  logic [3:0]      init_wstrb,
    output logic [1:0]      state_dbg
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;

    // Handshake rule: a beat (or an AR) transfers on a rising edge where valid and ready are both 1;
    // rvalid is never withdrawn and rdata/rresp/rlast/rid never change while rvalid=1 and rready=0.

    logic [31:0] mem [0:(2**DEPTH_LOG2)-1];

    logic [1:0]      state;
    logic            out_of_reset;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [7:0]      cnt;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [ID_W-1:0] id;
    logic            slverr;
    logic [31:0]     wait_cnt;

    logic        bubble;
    logic [31:0] wait_total;
    logic [31:0] step, wrap_mask, incr_addr, next_addr;
    logic [31:0] rd_addr, rd_off, init_off;
    logic [7:0]  rd_cnt;
    logic        rd_in_range, init_in_range, beat_hs, load;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign bubble     = (lfsr[1:0] == 2'b00);
    assign wait_total = 32'(LATENCY) + {28'd0, lfsr[3:0]};
`else
    assign bubble     = 1'b0;
    assign wait_total = 32'(LATENCY);
`endif

    assign arready   = (state == ST_IDLE) && out_of_reset;
    assign state_dbg = state;
    assign beat_hs   = rvalid && rready;

    always_comb begin
        step      = 32'd1 << size;
        wrap_mask = (({24'd0, len} + 32'd1) * step) - 32'd1;
        incr_addr = addr + step;
        unique case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    // A pending beat being accepted loads its successor in the same edge, so beats run back to back.
    assign rd_addr       = rvalid ? next_addr : addr;
    assign rd_cnt        = rvalid ? cnt + 8'd1 : cnt;
    assign rd_off        = rd_addr - BASE_ADDR;
    assign rd_in_range   = {1'b0, rd_off} < MEM_BYTES;
    assign init_off      = init_addr - BASE_ADDR;
    assign init_in_range = {1'b0, init_off} < MEM_BYTES;
    assign load          = (state == ST_BURST) && !bubble && (!rvalid || (beat_hs && !rlast));

    always_ff @(posedge clock) begin
        if (init_we && state == ST_IDLE && init_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (init_wstrb[b]) mem[init_off[DEPTH_LOG2+1:2]][8*b +: 8] <= init_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            out_of_reset <= 1'b0;
            addr         <= '0;
            len          <= '0;
            cnt          <= '0;
            size         <= '0;
            burst        <= '0;
            id           <= '0;
            slverr       <= 1'b0;
            wait_cnt     <= '0;
            rvalid       <= 1'b0;
            rdata        <= '0;
            rresp        <= '0;
            rlast        <= 1'b0;
            rid          <= '0;
        end else begin
            out_of_reset <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (arvalid && arready) begin
                        addr   <= araddr;
                        len    <= arlen;
                        size   <= arsize;
                        burst  <= arburst;
                        id     <= arid;
                        cnt    <= '0;
                        slverr <= (arsize > 3'd2) || ((arburst == 2'b10) &&
                                  !(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15));
                        if (wait_total == 32'd0) begin
                            state <= ST_BURST;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= wait_total - 32'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 32'd0) state <= ST_BURST;
                    else                   wait_cnt <= wait_cnt - 32'd1;
                end
                ST_BURST: begin
                    if (beat_hs) begin
                        addr   <= next_addr;
                        cnt    <= cnt + 8'd1;
                        rvalid <= 1'b0;
                        if (rlast) state <= ST_IDLE;
                    end
                    if (load) begin
                        rvalid <= 1'b1;
                        rid    <= id;
                        rlast  <= (rd_cnt == len);
                        if (slverr) begin
                            rresp <= 2'b10;
                            rdata <= '0;
                        end else if (!rd_in_range) begin
                            rresp <= 2'b11;
                            rdata <= '0;
                        end else begin
                            rresp <= 2'b00;
                            rdata <= mem[rd_off[DEPTH_LOG2+1:2]];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && init_we && state != ST_IDLE)
            $display("%m: init_we at %h while not IDLE, write dropped", init_addr);
    end
`endif

endmodule
